fetch_ctrl: RTL and testbench

Sequences the instruction-memory port for the fetch stage of the 5-stage RISC-V pipeline. It issues one request at a time for the current fetch PC, holds the fetch stage (`stallF`) until the instruction returns, and presents a NOP bubble to decode while waiting. On a taken branch or jump (`pcselE`), it drops any stale in-flight response. It sits between the fetch-stage PC register, the hazard unit and a variable-latency instruction memory.

---
 rtl/fetch_ctrl_if.sv | 11 +
 rtl/fetch_ctrl.sv | 104 ++++++++++
 tb/tb_fetch_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/response bundle between the fetch sequencer and imem.
interface fetch_ctrl_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch-stage instruction-memory sequencer: one outstanding request, NOP bubbles
// while waiting, stale-response drop on redirect, sticky response timeout.
//
// state | meaning
// IDLE  | post-reset, no request
// REQ   | request asserted, waiting for grant
// WAIT  | granted, waiting for the response
// HOLD  | response parked in the hold buffer while the hazard unit stalls fetch
// DROP  | redirected while a response is in flight; discard it when it arrives
module fetch_ctrl #(
  parameter logic [31:0] NOP     = 32'h0000_0013,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        pcF,
  input  logic               pcselE,
  input  logic               hazard_stallF,
  fetch_ctrl_if.master       imem,
  output logic [31:0]        instrF,
  output logic               stallF,
  output logic               err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DROP} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          err_q, err_d;
  logic [31:0]   hold_q, hold_d;
  logic          counting;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tmr_q   <= TMR_LOAD;
      err_q   <= 1'b0;
      hold_q  <= NOP;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
    end
  end

  assign imem.addr = pcF;

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    imem.req = 1'b0;
    instrF   = NOP;
    stallF   = !pcselE;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        imem.req = 1'b1;
        if (imem.gnt) state_d = pcselE ? DROP : WAIT;
      end
      WAIT: begin
        if (imem.rvalid) begin
          stallF = hazard_stallF & !pcselE;
          if (pcselE) begin
            state_d = REQ;
          end else begin
            instrF = imem.rdata;
            if (hazard_stallF) begin
              state_d = HOLD;
              hold_d  = imem.rdata;
            end else begin
              state_d = REQ;
            end
          end
        end else if (pcselE) begin
          state_d = DROP;
        end
      end
      HOLD: begin
        instrF = hold_q;
        stallF = hazard_stallF & !pcselE;
        if (pcselE || !hazard_stallF) state_d = REQ;
      end
      DROP: begin
        if (imem.rvalid) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  // Down-counter reloads whenever no response is being awaited; terminal count is the timeout.
  always_comb begin
    counting = ((state_q == WAIT) || (state_q == DROP)) && !imem.rvalid;
    if (counting) tmr_d = (tmr_q == '0) ? '0 : tmr_q - TW'(1);
    else          tmr_d = TMR_LOAD;
    err_d = err_q | (tmr_d == '0);
  end

  assign err = err_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: per-cycle vector table through a scoreboard, then a
// randomized-latency fetch sequence.
module tb_fetch_ctrl;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n, pcselE, hazard_stallF;
  logic [31:0] pcF;
  logic [31:0] instrF;
  logic        stallF, err;

  fetch_ctrl_if imem_if();

  fetch_ctrl #(.NOP(NOP), .TIMEOUT(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pcF           (pcF),
    .pcselE        (pcselE),
    .hazard_stallF (hazard_stallF),
    .imem          (imem_if),
    .instrF        (instrF),
    .stallF        (stallF),
    .err           (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst_n, pcsel, hst, gnt, rvalid;
    logic [31:0] pc, rdata;
    logic        e_req, e_stall, e_err;
    logic [31:0] e_instr;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        e_req, e_stall, e_err;
    logic [31:0] e_instr;
  } exp_t;

  vec_t        vecs[$];
  exp_t        sb[$];
  logic [31:0] rq[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic add(input string nm, input logic r, input logic [31:0] pc,
                     input logic ps, input logic hs, input logic g, input logic rv,
                     input logic [31:0] rd, input logic req, input logic [31:0] ins,
                     input logic st, input logic er);
    vec_t v;
    v.name = nm; v.rst_n = r; v.pc = pc; v.pcsel = ps; v.hst = hs; v.gnt = g;
    v.rvalid = rv; v.rdata = rd; v.e_req = req; v.e_instr = ins; v.e_stall = st;
    v.e_err = er;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic drive(input logic r, input logic [31:0] pc, input logic ps,
                       input logic hs, input logic g, input logic rv, input logic [31:0] rd);
    rst_n = r; pcF = pc; pcselE = ps; hazard_stallF = hs;
    imem_if.gnt = g; imem_if.rvalid = rv; imem_if.rdata = rd;
  endtask

  initial begin
    exp_t e;
    logic [31:0] val;
    int lat;

    //   name    rst pc          ps hs g  rv rdata          req instr         st er
    add("zw_idle", 1, 32'h000, 0, 0, 0, 0, 32'h0,          0, NOP,          1, 0);
    add("zw_req",  1, 32'h000, 0, 0, 1, 0, 32'h0,          1, NOP,          1, 0);
    add("zw_rsp",  1, 32'h000, 0, 0, 0, 1, 32'h00500093,   0, 32'h00500093, 0, 0);
    add("zw_req2", 1, 32'h004, 0, 0, 0, 0, 32'h0,          1, NOP,          1, 0);
    add("l3_req",  1, 32'h004, 0, 0, 1, 0, 32'h0,          1, NOP,          1, 0);
    add("l3_w1",   1, 32'h004, 0, 0, 0, 0, 32'h0,          0, NOP,          1, 0);
    add("l3_w2",   1, 32'h004, 0, 0, 0, 0, 32'h0,          0, NOP,          1, 0);
    add("l3_rsp",  1, 32'h004, 0, 0, 0, 1, 32'h00A00113,   0, 32'h00A00113, 0, 0);
    add("hz_req",  1, 32'h008, 0, 0, 1, 0, 32'h0,          1, NOP,          1, 0);
    add("hz_rsp",  1, 32'h008, 0, 1, 0, 1, 32'h002081B3,   0, 32'h002081B3, 1, 0);
    add("hz_hold", 1, 32'h008, 0, 1, 0, 0, 32'h11111111,   0, 32'h002081B3, 1, 0);
    add("hz_rel",  1, 32'h008, 0, 0, 0, 0, 32'h0,          0, 32'h002081B3, 0, 0);
    add("rw_req",  1, 32'h00C, 0, 0, 1, 0, 32'h0,          1, NOP,          1, 0);
    add("rw_redir",1, 32'h00C, 1, 0, 0, 0, 32'h0,          0, NOP,          0, 0);
    add("rw_drop", 1, 32'h100, 0, 0, 0, 0, 32'h0,          0, NOP,          1, 0);
    add("rw_stale",1, 32'h100, 0, 0, 0, 1, 32'hDEADBEEF,   0, NOP,          1, 0);
    add("rw_tgt",  1, 32'h100, 0, 0, 1, 0, 32'h0,          1, NOP,          1, 0);
    add("co_rsp",  1, 32'h100, 1, 0, 0, 1, 32'h12345678,   0, NOP,          0, 0);
    add("co_req",  1, 32'h200, 0, 0, 1, 0, 32'h0,          1, NOP,          1, 0);
    add("co_rsp2", 1, 32'h200, 0, 0, 0, 1, 32'h00000533,   0, 32'h00000533, 0, 0);
    add("gr_redir",1, 32'h204, 1, 0, 1, 0, 32'h0,          1, NOP,          0, 0);
    add("gr_drop2",1, 32'h300, 1, 0, 0, 0, 32'h0,          0, NOP,          0, 0);
    add("gr_stale",1, 32'h300, 0, 0, 0, 1, 32'h00000BAD,   0, NOP,          1, 0);
    add("gr_tgt",  1, 32'h300, 0, 0, 1, 0, 32'h0,          1, NOP,          1, 0);
    add("hr_rsp",  1, 32'h300, 0, 1, 0, 1, 32'h00100073,   0, 32'h00100073, 1, 0);
    add("hr_redir",1, 32'h300, 1, 1, 0, 0, 32'h0,          0, 32'h00100073, 0, 0);
    add("hr_req",  1, 32'h400, 0, 1, 0, 0, 32'h0,          1, NOP,          1, 0);
    add("rq_redir",1, 32'h400, 1, 0, 0, 0, 32'h0,          1, NOP,          0, 0);
    add("to_req",  1, 32'h500, 0, 0, 1, 0, 32'h0,          1, NOP,          1, 0);
    add("to_w1",   1, 32'h500, 0, 0, 0, 0, 32'h0,          0, NOP,          1, 0);
    add("to_w2",   1, 32'h500, 0, 0, 0, 0, 32'h0,          0, NOP,          1, 0);
    add("to_w3",   1, 32'h500, 0, 0, 0, 0, 32'h0,          0, NOP,          1, 0);
    add("to_w4",   1, 32'h500, 0, 0, 0, 0, 32'h0,          0, NOP,          1, 0);
    add("to_err",  1, 32'h500, 0, 0, 0, 0, 32'h0,          0, NOP,          1, 1);
    add("to_late", 1, 32'h500, 0, 0, 0, 1, 32'h00300193,   0, 32'h00300193, 0, 1);
    add("to_stick",1, 32'h504, 0, 0, 0, 0, 32'h0,          1, NOP,          1, 1);
    add("rs_mid",  0, 32'h504, 0, 0, 0, 0, 32'h0,          1, NOP,          1, 1);
    add("rs_idle", 1, 32'h000, 1, 0, 0, 0, 32'h0,          0, NOP,          0, 0);
    add("rs_req",  1, 32'h000, 0, 0, 0, 0, 32'h0,          1, NOP,          1, 0);

    drive(0, 32'h0, 0, 0, 0, 0, 32'h0);
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst_n, vecs[i].pc, vecs[i].pcsel, vecs[i].hst, vecs[i].gnt,
            vecs[i].rvalid, vecs[i].rdata);
      e.name = vecs[i].name; e.pc = vecs[i].pc; e.e_req = vecs[i].e_req;
      e.e_stall = vecs[i].e_stall; e.e_err = vecs[i].e_err; e.e_instr = vecs[i].e_instr;
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      chk({e.name, ".req"},    imem_if.req, e.e_req);
      chk({e.name, ".addr"},   imem_if.addr, e.pc);
      chk({e.name, ".instrF"}, instrF, e.e_instr);
      chk({e.name, ".stallF"}, stallF, e.e_stall);
      chk({e.name, ".err"},    err, e.e_err);
      @(posedge clk);
      #1;
    end

    // Random-latency fetches from REQ; latency kept below the timeout.
    for (int k = 0; k < 6; k++) begin
      val = $urandom;
      drive(1, 32'h600 + 32'(k * 4), 0, 0, 1, 0, 32'h0);
      rq.push_back(val);
      @(negedge clk);
      chk("rnd.req", imem_if.req, 1'b1);
      chk("rnd.req_stall", stallF, 1'b1);
      @(posedge clk); #1;
      lat = $urandom_range(1, 3);
      for (int j = 0; j < lat - 1; j++) begin
        drive(1, 32'h600 + 32'(k * 4), 0, 0, 0, 0, $urandom);
        @(negedge clk);
        chk("rnd.bubble", instrF, NOP);
        chk("rnd.wait_stall", stallF, 1'b1);
        @(posedge clk); #1;
      end
      drive(1, 32'h600 + 32'(k * 4), 0, 0, 0, 1, val);
      @(negedge clk);
      chk("rnd.instr", instrF, rq.pop_front());
      chk("rnd.rsp_stall", stallF, 1'b0);
      chk("rnd.err", err, 1'b0);
      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
